// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver with per-channel off/on/blink/PWM modes.
// Optional macro LED_BREATHE_EN turns mode 3 into a ramping breathe effect.
module led_pattern_gen #(
    parameter int unsigned CHANNELS       = 8,
    parameter int unsigned PRESCALE       = 100000,
    parameter int unsigned PERIOD_W       = 16,
    parameter int unsigned DEFAULT_PERIOD = 500,
    parameter int unsigned ADDR_W         = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cfg_wr_en,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [7:0]          cfg_duty,
    input  logic                sync,
    output logic                tick,
    output logic [CHANNELS-1:0] gpio_led
);
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

    logic [PRE_W-1:0]    pre_cnt;
    logic [PRE_W-1:0]    pre_nxt;
    logic [7:0]          pwm_cnt;

    logic [1:0]          mode      [CHANNELS];
    logic [PERIOD_W-1:0] period    [CHANNELS];
    logic [7:0]          duty      [CHANNELS];
    logic [PERIOD_W-1:0] cnt       [CHANNELS];
    logic                phase     [CHANNELS];
    logic [PERIOD_W-1:0] cnt_nxt   [CHANNELS];
    logic                phase_nxt [CHANNELS];
    logic [CHANNELS-1:0] led_nxt;
`ifdef LED_BREATHE_EN
    logic [7:0]          level     [CHANNELS];
    logic [7:0]          level_nxt [CHANNELS];
    logic                dir       [CHANNELS];
    logic                dir_nxt   [CHANNELS];
`endif

    assign pre_nxt = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);

    // Tick is registered so it is high exactly while pre_cnt sits at PRESCALE-1.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (sync) begin
                pre_cnt <= '0;
                tick    <= 1'b0;
            end else begin
                pre_cnt <= pre_nxt;
                tick    <= (pre_nxt == PRE_LAST);
            end
        end
    end

    // Per-channel next state assuming no write or sync this cycle.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i]   = cnt[i];
            phase_nxt[i] = phase[i];
            led_nxt[i]   = 1'b0;
`ifdef LED_BREATHE_EN
            level_nxt[i] = level[i];
            dir_nxt[i]   = dir[i];
            if (mode[i] != MODE_BLINK && mode[i] != MODE_PWM) begin
                level_nxt[i] = '0;
                dir_nxt[i]   = 1'b0;
`else
            if (mode[i] != MODE_BLINK) begin
`endif
                cnt_nxt[i]   = '0;
                phase_nxt[i] = 1'b0;
            end else if (tick) begin
                if (cnt[i] >= period[i]) begin
                    cnt_nxt[i]   = '0;
                    phase_nxt[i] = ~phase[i];
`ifdef LED_BREATHE_EN
                    // Triangle ramp 0..255..0, one step per completed phase.
                    if (!dir[i]) begin
                        level_nxt[i] = level[i] + 8'd1;
                        if (level[i] == 8'd254) dir_nxt[i] = 1'b1;
                    end else begin
                        level_nxt[i] = level[i] - 8'd1;
                        if (level[i] == 8'd1) dir_nxt[i] = 1'b0;
                    end
`endif
                end else begin
                    cnt_nxt[i] = cnt[i] + PERIOD_W'(1);
                end
            end

            case (mode[i])
                MODE_OFF:   led_nxt[i] = 1'b0;
                MODE_ON:    led_nxt[i] = 1'b1;
                MODE_BLINK: led_nxt[i] = phase[i];
`ifdef LED_BREATHE_EN
                default:    led_nxt[i] = (pwm_cnt < level[i]);
`else
                default:    led_nxt[i] = (pwm_cnt < duty[i]);
`endif
            endcase
        end
    end

    // Channel registers; reset beats write, write and sync both restart the channel.
    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!reset_n) begin
                mode[i]     <= MODE_OFF;
                period[i]   <= PERIOD_W'(DEFAULT_PERIOD);
                duty[i]     <= '0;
                cnt[i]      <= '0;
                phase[i]    <= 1'b0;
                gpio_led[i] <= 1'b0;
`ifdef LED_BREATHE_EN
                level[i]    <= '0;
                dir[i]      <= 1'b0;
`endif
            end else begin
                gpio_led[i] <= led_nxt[i];
                if (cfg_wr_en && cfg_addr == ADDR_W'(i)) begin
                    mode[i]   <= cfg_mode;
                    period[i] <= cfg_period;
                    duty[i]   <= cfg_duty;
                    cnt[i]    <= '0;
                    phase[i]  <= 1'b0;
`ifdef LED_BREATHE_EN
                    level[i]  <= '0;
                    dir[i]    <= 1'b0;
`endif
                end else if (sync) begin
                    cnt[i]    <= '0;
                    phase[i]  <= 1'b0;
`ifdef LED_BREATHE_EN
                    level[i]  <= '0;
                    dir[i]    <= 1'b0;
`endif
                end else begin
                    cnt[i]    <= cnt_nxt[i];
                    phase[i]  <= phase_nxt[i];
`ifdef LED_BREATHE_EN
                    level[i]  <= level_nxt[i];
                    dir[i]    <= dir_nxt[i];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: an arithmetic reference model predicts
// gpio_led/tick after every edge; a negedge monitor pops and compares.
module tb_led_pattern_gen;
    localparam int unsigned CHANNELS       = 8;
    localparam int unsigned PRESCALE       = 4;
    localparam int unsigned PERIOD_W       = 8;
    localparam int unsigned DEFAULT_PERIOD = 5;
    localparam int unsigned ADDR_W         = 4;

    logic                clock      = 1'b0;
    logic                reset_n    = 1'b0;
    logic                cfg_wr_en  = 1'b0;
    logic [ADDR_W-1:0]   cfg_addr   = '0;
    logic [1:0]          cfg_mode   = '0;
    logic [PERIOD_W-1:0] cfg_period = '0;
    logic [7:0]          cfg_duty   = '0;
    logic                sync       = 1'b0;
    logic                tick;
    logic [CHANNELS-1:0] gpio_led;

    led_pattern_gen #(
        .CHANNELS(CHANNELS), .PRESCALE(PRESCALE), .PERIOD_W(PERIOD_W),
        .DEFAULT_PERIOD(DEFAULT_PERIOD), .ADDR_W(ADDR_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .sync(sync), .tick(tick), .gpio_led(gpio_led)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [CHANNELS-1:0] led;
        logic                tck;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: per channel, ticks seen since last restart; phase/level follow arithmetically.
    bit   m_valid = 1'b0;
    int   m_mode[CHANNELS];
    int   m_period[CHANNELS];
    int   m_duty[CHANNELS];
    int   m_ticks[CHANNELS];
    int   pre_age;
    int   pwm_age;
    bit   m_tick;

    function automatic bit runs(int md);
`ifdef LED_BREATHE_EN
        return (md == 2) || (md == 3);
`else
        return (md == 2);
`endif
    endfunction

    function automatic bit led_of(int i);
        int n;
        int lvl;
        n = m_ticks[i] / (m_period[i] + 1);
        case (m_mode[i])
            0: return 1'b0;
            1: return 1'b1;
            2: return (n % 2) == 1;
            default: begin
`ifdef LED_BREATHE_EN
                lvl = n % 510;
                if (lvl > 255) lvl = 510 - lvl;
`else
                lvl = m_duty[i];
`endif
                return (pwm_age % 256) < lvl;
            end
        endcase
    endfunction

    always @(posedge clock) begin
        exp_t e;
        bit   tick_before;
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                m_mode[i] = 0; m_period[i] = DEFAULT_PERIOD; m_duty[i] = 0; m_ticks[i] = 0;
            end
            pre_age = 0; pwm_age = 0; m_tick = 1'b0; m_valid = 1'b1;
            e.led = '0; e.tck = 1'b0;
            exp_q.push_back(e);
        end else if (m_valid) begin
            for (int i = 0; i < CHANNELS; i++) e.led[i] = led_of(i);
            tick_before = m_tick;
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_wr_en && int'(cfg_addr) == i) begin
                    m_mode[i] = int'(cfg_mode); m_period[i] = int'(cfg_period);
                    m_duty[i] = int'(cfg_duty); m_ticks[i] = 0;
                end else if (sync || !runs(m_mode[i])) begin
                    m_ticks[i] = 0;
                end else if (tick_before) begin
                    m_ticks[i] = m_ticks[i] + 1;
                end
            end
            pwm_age = pwm_age + 1;
            if (sync) begin
                pre_age = 0; m_tick = 1'b0;
            end else begin
                pre_age = pre_age + 1;
                m_tick = (pre_age % PRESCALE) == (PRESCALE - 1);
            end
            e.tck = m_tick;
            exp_q.push_back(e);
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (gpio_led !== e.led) begin
                errors++;
                $display("FAIL gpio_led t=%0t got %b want %b", $time, gpio_led, e.led);
            end
            checks++;
            if (tick !== e.tck) begin
                errors++;
                $display("FAIL tick t=%0t got %b want %b", $time, tick, e.tck);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input int a, input int m, input int p, input int d);
        @(negedge clock);
        cfg_wr_en = 1'b1; cfg_addr = ADDR_W'(a); cfg_mode = 2'(m);
        cfg_period = PERIOD_W'(p); cfg_duty = 8'(d);
        @(negedge clock);
        cfg_wr_en = 1'b0;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        int cnt;
        step(3);
        reset_n = 1'b1;

        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (tick) cnt++;
        end
        check_int("tick_rate", cnt, 40 / PRESCALE);

        wr(2, 2, 1, 0);
        step(40);

        // ON latency: written before edge k, visible only after edge k+1.
        @(negedge clock);
        cfg_wr_en = 1'b1; cfg_addr = ADDR_W'(0); cfg_mode = 2'd1; cfg_period = '0; cfg_duty = '0;
        @(negedge clock);
        cfg_wr_en = 1'b0;
        check_int("on_before", int'(gpio_led[0]), 0);
        @(negedge clock);
        check_int("on_after", int'(gpio_led[0]), 1);

`ifndef LED_BREATHE_EN
        wr(5, 3, 0, 64);
        step(1);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clock);
            if (gpio_led[5]) cnt++;
        end
        check_int("pwm_duty64", cnt, 64);
        wr(5, 3, 0, 0);
        step(1);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clock);
            if (gpio_led[5]) cnt++;
        end
        check_int("pwm_duty0", cnt, 0);
`endif

        wr(CHANNELS, 1, 0, 0);
        wr(15, 2, 0, 0);
        step(10);

        wr(3, 2, 2, 0);
        step(5);
        wr(4, 2, 2, 0);
        step(13);
        @(negedge clock); sync = 1'b1;
        @(negedge clock); sync = 1'b0;
        step(1);
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (gpio_led[3] !== gpio_led[4]) cnt++;
        end
        check_int("sync_align", cnt, 0);

        @(negedge clock);
        reset_n = 1'b0; cfg_wr_en = 1'b1; cfg_addr = ADDR_W'(1); cfg_mode = 2'd1;
        @(negedge clock);
        reset_n = 1'b1; cfg_wr_en = 1'b0;
        step(5);
        check_int("reset_wr_led", int'(gpio_led), 0);

`ifdef LED_BREATHE_EN
        wr(6, 3, 0, 0);
        step(PRESCALE * 600);
`endif

        for (int n = 0; n < 600; n++) begin
            @(negedge clock);
            cfg_wr_en  = ($urandom_range(0, 99) < 40);
            cfg_addr   = ADDR_W'($urandom_range(0, 15));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = PERIOD_W'($urandom_range(0, 3));
            cfg_duty   = 8'($urandom_range(0, 255));
            sync       = ($urandom_range(0, 99) < 5);
            reset_n    = ($urandom_range(0, 199) != 0);
            @(negedge clock);
            cfg_wr_en = 1'b0; sync = 1'b0; reset_n = 1'b1;
            repeat ($urandom_range(0, 15)) @(negedge clock);
        end

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised multi-channel LED driver, the next generation of the board's fixed-rate LED blinker. Each channel has its own run-time mode (off, on, blink, PWM) and its own blink period and duty. Channels are configured through a single-cycle write port. The block sits behind the clock-wizard output and drives the board GPIO LEDs directly.

Parameters:
CHANNELS, 8, number of LED outputs (1..32)
PRESCALE, 100000, clocks per tick; 1 ms tick at 100 MHz; must be >= 1
PERIOD_W, 16, width of the per-channel blink period in ticks
DEFAULT_PERIOD, 500, blink period loaded at reset (ticks)
ADDR_W, 5, width of cfg_addr; must satisfy 2**ADDR_W >= CHANNELS

Ports:
clock  input  1  system clock, all logic on posedge
reset_n  input  1  synchronous, active-low reset
cfg_wr_en  input  1  write strobe; one write per asserted cycle
cfg_addr  input  ADDR_W  target channel index
cfg_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=PWM
cfg_period  input  PERIOD_W  blink half-period in ticks, minus 1
cfg_duty  input  8  PWM duty, out of 256
sync  input  1  single-cycle pulse; re-phases all channels
tick  output  1  one-cycle pulse every PRESCALE clocks (status/debug)
gpio_led  output  CHANNELS  registered LED drive, 1 = lit

Behaviour:
- Reset (reset_n=0 at posedge):
  - Prescaler, pwm_cnt, all blink counters and phases cleared.
  - All modes = OFF, period = DEFAULT_PERIOD, duty = 0.
  - Outputs: gpio_led = 0, tick = 0.
  - Reset mid-operation takes effect on the same edge and overrides write and sync.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick=1 for the one cycle in which the count equals PRESCALE-1.
  - PRESCALE=1 gives tick=1 every cycle.
- PWM counter:
  - pwm_cnt is 8 bits, shared by all channels, increments every clock and wraps 255 to 0.
- BLINK, per channel:
  - On tick: if cnt >= period, toggle phase and set cnt = 0; else cnt = cnt+1.
  - Each phase therefore lasts period+1 ticks.
  - period=0 toggles on every tick.
  - cnt and period are PERIOD_W wide; no overflow is possible.
- Output, per channel, registered:
  - OFF gives 0; ON gives 1; BLINK gives phase.
  - PWM gives (pwm_cnt < duty): duty=0 is always off, duty=255 is lit 255 of 256 cycles.
  - Blink counters run only in BLINK mode and hold at 0 in the other modes.
- Config write:
  - A write with cfg_wr_en=1 and cfg_addr < CHANNELS updates mode, period and duty at edge k.
  - The same write clears that channel's cnt and phase.
  - gpio_led reflects the new configuration after edge k+1 (latency 1).
  - A write with cfg_addr >= CHANNELS is ignored; no state changes.
- sync:
  - Clears the prescaler and all blink cnt/phase; pwm_cnt is not affected.
  - No tick is produced on the sync cycle.
  - sync and a write in the same cycle: both apply; the written channel takes the new config with cnt/phase = 0.
- Write to a channel already in BLINK: the phase restarts at 0 (LED off) immediately after edge k+1.

Optional Feature:
- LED_BREATHE_EN defined:
  - Mode 3 becomes breathe: a per-channel 8-bit level ramps up by 1 per completed blink phase (same period/cnt logic) from 0 to 255, then down to 0, repeating.
  - Output = (pwm_cnt < level); cfg_duty is ignored in this mode.
  - Level and direction are cleared by reset, sync and config write.
- LED_BREATHE_EN undefined:
  - Mode 3 is fixed-duty PWM as above.
  - No level registers are synthesised.

Test Plan:
- Reset: PRESCALE=4, hold reset_n=0 for 3 cycles then release -> gpio_led=0; first tick on the 4th clock after release, then every 4 clocks.
- Blink: write ch2 mode=2, period=1 -> gpio_led[2] toggles every 2 ticks (8 clocks); the other bits stay 0.
- ON and latency: write ch0 mode=1 at edge k -> gpio_led[0]=1 after edge k+1, not before.
- PWM: write ch5 mode=3, duty=64 -> over any 256-cycle window gpio_led[5] is high for exactly 64 cycles; duty=0 gives 0 high cycles.
- Invalid write and sync: write with cfg_addr=CHANNELS -> no change; two BLINK channels with equal period but offset phase, pulse sync -> the channels toggle on identical cycles thereafter.
- Reset mid-blink plus simultaneous write: assert reset_n=0 in the same cycle as cfg_wr_en=1 -> all modes OFF, write discarded; with LED_BREATHE_EN, mode 3 with period=0 -> level reaches 255 after 255 ticks, then decreases.
